wb_move_seq: RTL and testbench



---
 rtl/move_seq_pkg.sv | 33 +++
 rtl/move_fifo.sv | 65 ++++++
 rtl/wb_move_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_wb_move_seq.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/move_seq_pkg.sv
// Shared constants for the servo move sequencer: register map, CMD field layout,
// STATUS/CTRL bit positions and the sequencer state encoding.
package move_seq_pkg;

    localparam logic [1:0] REG_CMD    = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_COUNT  = 2'd3;

    localparam int unsigned CMD_WIDTH_LSB = 0;
    localparam int unsigned CMD_WIDTH_W   = 16;
    localparam int unsigned CMD_DWELL_LSB = 16;
    localparam int unsigned CMD_CH_LSB    = 28;
    localparam int unsigned CMD_CH_W      = 3;

    localparam int unsigned ST_BUSY      = 0;
    localparam int unsigned ST_EMPTY     = 1;
    localparam int unsigned ST_FULL      = 2;
    localparam int unsigned ST_OVF       = 3;
    localparam int unsigned ST_DONE      = 4;
    localparam int unsigned ST_LEVEL_LSB = 8;

    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_FLUSH = 1;
    localparam int unsigned CTRL_IE    = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StDwell = 2'd2
    } seq_state_e;

endpackage

// File: rtl/move_fifo.sv
// Synchronous command FIFO with level/full/empty flags and a synchronous clear.
// A push while full is ignored; a pop while empty is ignored.
module move_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 31
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    assign full_o  = (level_q == (AW + 1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Full is judged on the pre-pop level, so a push into a full queue drops even with a pop.
    assign do_push = push_i & ~full_o & ~clr_i;
    assign do_pop  = pop_i & ~empty_o & ~clr_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + 1'b1;
            end else if (!do_push && do_pop) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/wb_move_seq.sv
// Wishbone servo move sequencer: queues {ch, dwell, width} commands and plays them
// out on the PWM load port. Build option WB_MOVE_SEQ_IRQ_EN enables intr_o and CTRL.ie.
module wb_move_seq
    import move_seq_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DWELL_W    = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic [2:0]  pwm_ch_o,
    output logic [15:0] pwm_width_o,
    output logic        pwm_load_o,
    output logic        busy_o,
    output logic        intr_o
);

    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ENTRY_W   = CMD_CH_W + DWELL_W + CMD_WIDTH_W;
    localparam int unsigned PRESC_MAX = CLK_FREQ / 1000 - 1;

    // Bus request is captured on the request edge; side effects apply during the ack cycle.
    logic        ack_q, req_we_q;
    logic [1:0]  req_adr_q;
    logic [31:0] req_dat_q, dat_q, rdata;
    logic        wb_req;

    logic wr_cmd, wr_status, wr_ctrl, wr_count, flush;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;
    logic [LVL_W-1:0]   fifo_level;

    seq_state_e state_q, state_d;
    logic       start, dwell_done;

    logic [2:0]         pwm_ch_q;
    logic [15:0]        pwm_width_q;
    logic [DWELL_W-1:0] dwell_cnt_q;
    logic [31:0]        presc_q;
    logic [15:0]        count_q, count_d;
    logic               en_q, ovf_q, ovf_d, done_q, done_d, ie_bit;

    logic unused_bits;
    assign unused_bits = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], req_dat_q};

    assign wb_req = wb_cyc_i & wb_stb_i & ~ack_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q     <= 1'b0;
            req_we_q  <= 1'b0;
            req_adr_q <= '0;
            req_dat_q <= '0;
            dat_q     <= '0;
        end else begin
            ack_q <= wb_req;
            dat_q <= (wb_req && !wb_we_i) ? rdata : '0;
            if (wb_req) begin
                req_we_q  <= wb_we_i;
                req_adr_q <= wb_adr_i[3:2];
                req_dat_q <= wb_dat_i;
            end
        end
    end

    assign wb_ack_o  = ack_q;
    assign wb_dat_o  = dat_q;
    assign wr_cmd    = ack_q & req_we_q & (req_adr_q == REG_CMD);
    assign wr_status = ack_q & req_we_q & (req_adr_q == REG_STATUS);
    assign wr_ctrl   = ack_q & req_we_q & (req_adr_q == REG_CTRL);
    assign wr_count  = ack_q & req_we_q & (req_adr_q == REG_COUNT);
    assign flush     = wr_ctrl & req_dat_q[CTRL_FLUSH];

    assign fifo_push  = wr_cmd;
    assign fifo_wdata = {req_dat_q[CMD_CH_LSB +: CMD_CH_W],
                         req_dat_q[CMD_DWELL_LSB +: DWELL_W],
                         req_dat_q[CMD_WIDTH_LSB +: CMD_WIDTH_W]};

    move_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (flush),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (fifo_wdata),
        .data_o  (fifo_rdata),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign start      = en_q & ~fifo_empty & ~flush;
    assign fifo_pop   = (state_q == StIdle) & start;
    assign dwell_done = (state_q == StDwell) & ~flush & (dwell_cnt_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StLoad;
            StLoad:  state_d = flush ? StIdle : StDwell;
            StDwell: if (flush || dwell_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o     = (state_q != StIdle);
        pwm_load_o = (state_q == StLoad);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_ch_q    <= '0;
            pwm_width_q <= '0;
            dwell_cnt_q <= '0;
            presc_q     <= '0;
        end else begin
            if (fifo_pop) begin
                pwm_ch_q    <= fifo_rdata[ENTRY_W-1 -: CMD_CH_W];
                pwm_width_q <= fifo_rdata[CMD_WIDTH_W-1:0];
                dwell_cnt_q <= fifo_rdata[CMD_WIDTH_W +: DWELL_W];
            end
            if (state_q == StLoad) begin
                presc_q <= '0;
            end else if (state_q == StDwell && !flush && !dwell_done) begin
                if (presc_q == PRESC_MAX) begin
                    presc_q     <= '0;
                    dwell_cnt_q <= dwell_cnt_q - 1'b1;
                end else begin
                    presc_q <= presc_q + 32'd1;
                end
            end
        end
    end

    assign pwm_ch_o    = pwm_ch_q;
    assign pwm_width_o = pwm_width_q;

    // Sticky sets take priority over a same-cycle write-1-to-clear.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_status && req_dat_q[ST_OVF]) ovf_d = 1'b0;
        if (wr_cmd && fifo_full) ovf_d = 1'b1;

        done_d = done_q;
        if (wr_status && req_dat_q[ST_DONE]) done_d = 1'b0;
        if (dwell_done && fifo_empty) done_d = 1'b1;

        count_d = wr_count ? 16'd0 : count_q;
        if (dwell_done) count_d = count_d + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q    <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            count_q <= count_d;
            if (wr_ctrl) begin
                en_q <= req_dat_q[CTRL_EN];
            end
        end
    end

`ifdef WB_MOVE_SEQ_IRQ_EN
    logic ie_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ie_q <= 1'b0;
        end else if (wr_ctrl) begin
            ie_q <= req_dat_q[CTRL_IE];
        end
    end

    assign ie_bit = ie_q;
    assign intr_o = done_q & ie_q;
`else
    assign ie_bit = 1'b0;
    assign intr_o = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (wb_adr_i[3:2])
            REG_STATUS: begin
                rdata[ST_BUSY]                  = busy_o;
                rdata[ST_EMPTY]                 = fifo_empty;
                rdata[ST_FULL]                  = fifo_full;
                rdata[ST_OVF]                   = ovf_q;
                rdata[ST_DONE]                  = done_q;
                rdata[ST_LEVEL_LSB +: LVL_W]    = fifo_level;
            end
            REG_CTRL: begin
                rdata[CTRL_EN] = en_q;
                rdata[CTRL_IE] = ie_bit;
            end
            REG_COUNT: rdata[15:0] = count_q;
            default:   rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_wb_move_seq.sv
// Scoreboard bench for wb_move_seq at 1000 cycles/ms: expected PWM loads and bus reads
// are queued at stimulus time and checked by a monitor when the DUT presents them.
module tb_wb_move_seq;

    localparam int unsigned CLK_FREQ = 1000000;
`ifdef WB_MOVE_SEQ_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
    logic        wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_ack_o;
    logic [3:0]  wb_sel_i = 4'hf;
    logic [2:0]  pwm_ch_o;
    logic [15:0] pwm_width_o;
    logic        pwm_load_o, busy_o, intr_o;

    wb_move_seq #(
        .CLK_FREQ   (CLK_FREQ),
        .FIFO_DEPTH (8),
        .DWELL_W    (12)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_adr_i    (wb_adr_i),
        .wb_dat_i    (wb_dat_i),
        .wb_dat_o    (wb_dat_o),
        .wb_we_i     (wb_we_i),
        .wb_cyc_i    (wb_cyc_i),
        .wb_stb_i    (wb_stb_i),
        .wb_sel_i    (wb_sel_i),
        .wb_ack_o    (wb_ack_o),
        .pwm_ch_o    (pwm_ch_o),
        .pwm_width_o (pwm_width_o),
        .pwm_load_o  (pwm_load_o),
        .busy_o      (busy_o),
        .intr_o      (intr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] val;
    } rd_exp_t;

    rd_exp_t     exp_rd[$];
    logic [18:0] exp_ld[$];
    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int last_load_cyc = 0;
    int last_ack_cyc = 0;

    always @(posedge clk) cyc_cnt++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT strobes a load or acks a read.
    always @(negedge clk) begin
        if (rst) begin
            if (pwm_load_o) begin
                last_load_cyc = cyc_cnt;
                if (exp_ld.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_load: got ch=%0d width=%0d, expected none",
                             pwm_ch_o, pwm_width_o);
                end else begin
                    check("pwm_load", {45'd0, pwm_ch_o, pwm_width_o},
                          {45'd0, exp_ld.pop_front()});
                end
            end
            if (wb_ack_o) begin
                last_ack_cyc = cyc_cnt;
                if (!wb_we_i) begin
                    if (exp_rd.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_read: got 0x%0h, expected none", wb_dat_o);
                    end else begin
                        rd_exp_t e;
                        e = exp_rd.pop_front();
                        check(e.name, {32'd0, wb_dat_o}, {32'd0, e.val});
                    end
                end
            end
        end
    end

    task automatic wb_xfer(input logic we, input logic [1:0] rg, input logic [31:0] dat);
        int n = 0;
        wb_adr_i = {28'd0, rg, 2'b00};
        wb_dat_i = dat;
        wb_we_i  = we;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!wb_ack_o && n < 20);
        if (!wb_ack_o) begin
            checks++;
            errors++;
            $display("FAIL wb_ack_timeout: got no ack, expected ack within 20 cycles");
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [1:0] rg, input logic [31:0] dat);
        wb_xfer(1'b1, rg, dat);
    endtask

    task automatic wb_read(input string name, input logic [1:0] rg, input logic [31:0] exp);
        exp_rd.push_back('{name, exp});
        wb_xfer(1'b0, rg, 32'd0);
    endtask

    task automatic push_cmd(input int ch, input int dwell, input int width, input bit expect_ld);
        logic [31:0] c;
        c = (32'(ch) << 28) | (32'(dwell) << 16) | 32'(width);
        if (expect_ld) exp_ld.push_back({3'(ch), 16'(width)});
        wb_write(2'd0, c);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!(exp_ld.size() == 0 && !busy_o) && n < budget);
        check(name, {63'd0, (exp_ld.size() == 0 && !busy_o)}, 64'd1);
    endtask

    task automatic wait_load(input string name, input int budget);
        int n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (exp_ld.size() != 0 && n < budget);
        check(name, {63'd0, (exp_ld.size() == 0)}, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        check("reset_outputs", {pwm_ch_o, pwm_width_o, pwm_load_o, busy_o, intr_o, wb_ack_o},
              64'd0);
        wb_read("reset_status", 2'd1, 32'h2);
        wb_read("reset_ctrl", 2'd2, 32'h0);
        wb_read("reset_count", 2'd3, 32'h0);

        // Scenario 1: single move, dwell 3 ms.
        wb_write(2'd2, 32'h1);
        push_cmd(2, 3, 1500, 1'b1);
        wait_idle("s1_complete", 4000);
        check("s1_latency", 64'(last_load_cyc - last_ack_cyc), 64'd2);  // ack, pop, load
        check("s1_busy_len", 64'(cyc_cnt - last_load_cyc), 64'd3002);
        wb_read("s1_count", 2'd3, 32'h1);
        wb_read("s1_status", 2'd1, 32'h12);
        wb_write(2'd1, 32'h10);

        // Scenario 2: overflow while disabled, then drain in order.
        wb_write(2'd2, 32'h0);
        for (int i = 0; i < 9; i++) push_cmd(i % 8, 0, 100 + i, i < 8);
        wb_read("s2_status_full", 2'd1, 32'h80C);
        wb_write(2'd1, 32'h08);
        wb_write(2'd3, 32'h0);
        wb_write(2'd2, 32'h1);
        wait_idle("s2_drain", 500);
        wb_read("s2_count", 2'd3, 32'h8);
        wb_read("s2_status", 2'd1, 32'h12);
        wb_write(2'd1, 32'h10);

        // Scenario 3: disable mid-move, second move held until re-enabled.
        wb_write(2'd3, 32'h0);
        push_cmd(1, 5, 1111, 1'b1);
        push_cmd(3, 0, 2222, 1'b0);
        wb_write(2'd2, 32'h0);
        wait_idle("s3_first", 7000);
        wb_read("s3_count", 2'd3, 32'h1);
        wb_read("s3_status", 2'd1, 32'h100);
        repeat (20) @(posedge clk);
        #2 check("s3_held", {63'd0, busy_o}, 64'd0);
        exp_ld.push_back({3'd3, 16'd2222});
        wb_write(2'd2, 32'h1);
        wait_idle("s3_second", 100);
        check("s3_zero_dwell", 64'(cyc_cnt - last_load_cyc), 64'd2);
        wb_read("s3_count2", 2'd3, 32'h2);
        wb_read("s3_status2", 2'd1, 32'h12);
        wb_write(2'd1, 32'h10);

        // Scenario 4: flush during the first of three dwells.
        wb_write(2'd2, 32'h0);
        wb_write(2'd3, 32'h0);
        push_cmd(4, 2, 3000, 1'b1);
        push_cmd(5, 2, 4000, 1'b0);
        push_cmd(6, 2, 5000, 1'b0);
        wb_write(2'd2, 32'h1);
        wait_load("s4_load", 50);
        repeat (50) @(posedge clk);
        #1 wb_write(2'd2, 32'h3);
        check("s4_idle", {63'd0, busy_o}, 64'd0);
        check("s4_hold_pwm", {45'd0, pwm_ch_o, pwm_width_o}, {45'd0, 3'd4, 16'd3000});
        wb_read("s4_status", 2'd1, 32'h2);
        wb_read("s4_count", 2'd3, 32'h0);
        repeat (100) @(posedge clk);
        #2 check("s4_stay_idle", {63'd0, busy_o}, 64'd0);

        // Scenario 5: interrupt on completion, cleared via STATUS.done.
        wb_write(2'd2, 32'h5);
        wb_read("s5_ctrl", 2'd2, IRQ ? 32'h5 : 32'h1);
        push_cmd(7, 0, 77, 1'b1);
        wait_idle("s5_complete", 100);
        check("s5_intr_set", {63'd0, intr_o}, {63'd0, IRQ});
        wb_read("s5_status", 2'd1, 32'h12);
        wb_write(2'd1, 32'h10);
        check("s5_intr_clr", {63'd0, intr_o}, 64'd0);
        wb_read("s5_status2", 2'd1, 32'h2);
        wb_read("s5_count", 2'd3, 32'h1);

        // Scenario 6: reset during dwell, then a fresh move.
        push_cmd(2, 3, 1500, 1'b1);
        wait_load("s6_load", 50);
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        #1 check("s6_reset_outputs",
                 {pwm_ch_o, pwm_width_o, pwm_load_o, busy_o, intr_o, wb_ack_o}, 64'd0);
        check("s6_reset_dat", {32'd0, wb_dat_o}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        wb_read("s6_status", 2'd1, 32'h2);
        wb_read("s6_ctrl", 2'd2, 32'h0);
        wb_read("s6_count", 2'd3, 32'h0);
        wb_write(2'd2, 32'h1);
        push_cmd(2, 3, 1500, 1'b1);
        wait_idle("s6_complete", 4000);
        check("s6_latency", 64'(last_load_cyc - last_ack_cyc), 64'd2);
        check("s6_busy_len", 64'(cyc_cnt - last_load_cyc), 64'd3002);
        wb_read("s6_count2", 2'd3, 32'h1);
        wb_read("s6_status2", 2'd1, 32'h12);

        repeat (2) @(posedge clk);
        check("exp_load_drained", 64'(exp_ld.size()), 64'd0);
        check("exp_read_drained", 64'(exp_rd.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
